// File: rtl/fft_pair_sequencer.sv
// Buffers one frame of samples, then streams them out as radix-2 butterfly pairs
// for the selected stage (span = 1 << stage), with valid/ready handshakes on both sides.
module fft_pair_sequencer #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(SAMPLES)-1:0]  stage,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(SAMPLES)-1:0]  out_idx_a,
  output logic [$clog2(SAMPLES)-1:0]  out_idx_b,
  output logic [WIDTH-1:0]            out_a,
  output logic [WIDTH-1:0]            out_b,
  output logic                        out_last,
  output logic                        stage_err
);
  // state | meaning
  // LOAD  | accepting samples into buffer[load_cnt]; stage latched on the first one
  // EMIT  | presenting butterfly pair p; advances on out_ready

  localparam int LOGS = $clog2(SAMPLES);
  localparam int PW   = LOGS - 1;
  localparam logic [LOGS-1:0] LOAD_LAST = LOGS'(SAMPLES - 1);
  localparam logic [PW-1:0]   PAIR_LAST = PW'(SAMPLES / 2 - 1);
  localparam logic [LOGS-1:0] STAGE_MAX = LOGS'(LOGS - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t            state;
  logic [LOGS-1:0]   load_cnt;
  logic [PW-1:0]     p;
  logic [LOGS-1:0]   s;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  buffer [SAMPLES];

  logic              accept;
  logic [LOGS-1:0]   p_ext;
  logic [LOGS-1:0]   low_mask;
  logic [LOGS-1:0]   idx_a;
  logic [LOGS-1:0]   idx_b;

  assign accept = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      load_cnt    <= '0;
      p           <= '0;
      s           <= '0;
      stage_err   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            // stage is sampled only with the first sample so the frame is self-consistent
            if (load_cnt == '0) begin
              if (stage > STAGE_MAX) begin
                s         <= STAGE_MAX;
                stage_err <= 1'b1;
              end else begin
                s <= stage;
              end
            end
            if (load_cnt == LOAD_LAST) begin
              load_cnt    <= '0;
              state       <= EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (p == PAIR_LAST) begin
              p           <= '0;
              state       <= LOAD;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) buffer[load_cnt] <= in_data;
  end

  // insert a zero at bit position s of p to get the lower index of the pair
  always_comb begin
    p_ext    = {1'b0, p};
    low_mask = (LOGS'(1) << s) - LOGS'(1);
    idx_a    = ((p_ext >> s) << (s + 1'b1)) | (p_ext & low_mask);
    idx_b    = idx_a | (LOGS'(1) << s);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_idx_a = idx_a;
  assign out_idx_b = idx_b;
  assign out_a     = buffer[idx_a];
  assign out_b     = buffer[idx_b];
  assign out_last  = out_valid_q && (p == PAIR_LAST);

endmodule
